fetch_align_ctrl: RTL

Instruction-fetch alignment controller between the word-addressed instruction memory and the compressed-instruction expander/decode stage. It issues word fetches, tracks a halfword-granular PC, and splits each 32-bit fetch word into 16-bit (compressed) or 32-bit instructions. It stitches 32-bit instructions that straddle a word boundary and presents one instruction per handshake, tagged with its PC and a compressed flag that drives the expander's select.

---
 rtl/fetch_pkg.sv | 17 +
 rtl/fetch_align_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for fetch_align_ctrl: FSM states, RVC length rule, default reset PC.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_LINE = 2'd2
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // A halfword starts a 16-bit instruction unless its two low bits are 2'b11.
   function automatic logic is_comp(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/fetch_align_ctrl.sv
// Instruction-fetch alignment controller: word fetches, halfword PC, RVC split and straddle stitching.
// Compressed support is built only when FETCH_ALIGN_RVC_EN is defined.
module fetch_align_ctrl
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        inst_comp,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   fetch_state_e state_q;
   logic [31:2]  fetch_pc_q;
   logic [31:0]  line_q;
   logic         drop_q;
   logic         inst_valid_q;
   logic [31:0]  inst_data_q;
   logic [31:0]  inst_pc_q;

   logic         can_emit;
   logic         stale;
   logic         unused_redirect;

   assign can_emit  = !inst_valid_q || inst_ready;
   // A redirect while a request is in flight must swallow that response later.
   assign stale     = (state_q == S_WAIT) && !imem_rvalid;

   assign imem_req   = (state_q == S_REQ) && !rst && !redirect_valid;
   assign imem_addr  = {fetch_pc_q, 2'b00};
   assign inst_valid = inst_valid_q;
   assign inst_data  = inst_data_q;
   assign inst_pc    = inst_pc_q;

`ifdef FETCH_ALIGN_RVC_EN
   logic         hptr_q;
   logic [15:0]  spill_q;
   logic [31:2]  spill_pc_q;
   logic         spill_valid_q;
   logic         inst_comp_q;
   logic [15:0]  half;

   assign half            = hptr_q ? line_q[31:16] : line_q[15:0];
   assign inst_comp       = inst_comp_q;
   assign unused_redirect = redirect_pc[0];
`else
   assign inst_comp       = 1'b0;
   assign unused_redirect = ^redirect_pc[1:0];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_REQ;
         fetch_pc_q    <= RESET_PC[31:2];
         line_q        <= '0;
         drop_q        <= 1'b0;
         inst_valid_q  <= 1'b0;
         inst_data_q   <= '0;
         inst_pc_q     <= '0;
`ifdef FETCH_ALIGN_RVC_EN
         hptr_q        <= RESET_PC[1];
         spill_q       <= '0;
         spill_pc_q    <= '0;
         spill_valid_q <= 1'b0;
         inst_comp_q   <= 1'b0;
`endif
      end else if (redirect_valid) begin
         state_q      <= stale ? S_WAIT : S_REQ;
         drop_q       <= stale;
         fetch_pc_q   <= redirect_pc[31:2];
         inst_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_RVC_EN
         hptr_q        <= redirect_pc[1];
         spill_valid_q <= 1'b0;
`endif
      end else begin
         // A new instruction loaded below overrides this accept-clear.
         if (inst_valid_q && inst_ready) inst_valid_q <= 1'b0;
         case (state_q)
            S_REQ: state_q <= S_WAIT;
            S_WAIT: begin
               if (imem_rvalid) begin
                  if (drop_q) begin
                     drop_q  <= 1'b0;
                     state_q <= S_REQ;
                  end else begin
                     line_q  <= imem_rdata;
                     state_q <= S_LINE;
                  end
               end
            end
            S_LINE: begin
`ifdef FETCH_ALIGN_RVC_EN
               if (spill_valid_q) begin
                  if (can_emit) begin
                     inst_valid_q  <= 1'b1;
                     inst_data_q   <= {line_q[15:0], spill_q};
                     inst_pc_q     <= {spill_pc_q, 2'b10};
                     inst_comp_q   <= 1'b0;
                     spill_valid_q <= 1'b0;
                     hptr_q        <= 1'b1;
                  end
               end else if (is_comp(half)) begin
                  if (can_emit) begin
                     inst_valid_q <= 1'b1;
                     inst_data_q  <= {16'h0000, half};
                     inst_pc_q    <= {fetch_pc_q, hptr_q, 1'b0};
                     inst_comp_q  <= 1'b1;
                     if (hptr_q) begin
                        state_q    <= S_REQ;
                        fetch_pc_q <= fetch_pc_q + 30'd1;
                        hptr_q     <= 1'b0;
                     end else begin
                        hptr_q <= 1'b1;
                     end
                  end
               end else if (!hptr_q) begin
                  if (can_emit) begin
                     inst_valid_q <= 1'b1;
                     inst_data_q  <= line_q;
                     inst_pc_q    <= {fetch_pc_q, 2'b00};
                     inst_comp_q  <= 1'b0;
                     state_q      <= S_REQ;
                     fetch_pc_q   <= fetch_pc_q + 30'd1;
                  end
               end else begin
                  // Upper half opens a 32-bit instruction: park it and fetch the next word.
                  spill_q       <= half;
                  spill_pc_q    <= fetch_pc_q;
                  spill_valid_q <= 1'b1;
                  state_q       <= S_REQ;
                  fetch_pc_q    <= fetch_pc_q + 30'd1;
                  hptr_q        <= 1'b0;
               end
`else
               if (can_emit) begin
                  inst_valid_q <= 1'b1;
                  inst_data_q  <= line_q;
                  inst_pc_q    <= {fetch_pc_q, 2'b00};
                  state_q      <= S_REQ;
                  fetch_pc_q   <= fetch_pc_q + 30'd1;
               end
`endif
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

endmodule
